axi_stream_header_insert: RTL and testbench
===========================================

Name: axi_stream_header_insert

Overview:
- AXI-Stream header inserter: accepts one header word per packet, then the payload packet.
- Emits a single repacked stream: the valid header bytes, immediately followed by the payload bytes, with no gaps.
- Sits between a payload source and a downstream AXI-Stream sink.
- Header source and payload source are separate AXI-Stream masters.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (derived, W below).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte-count width minus 1 (derived).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-high (1 = reset).
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload data; byte 0 (first on wire) = [DATA_WD-1:DATA_WD-8].
- keep_in  in  DATA_BYTE_WD  byte enables; all ones except last beat, left-aligned (e.g. 1110).
- last_in  in  1  last payload beat.
- ready_in  out  1  payload ready.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  output data, same byte order.
- keep_out  out  DATA_BYTE_WD  left-aligned contiguous enables.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header; valid bytes right-aligned (least significant).
- keep_insert  in  DATA_BYTE_WD  header enables, right-aligned (e.g. 0011).
- byte_insert_cnt  in  BYTE_CNT_WD+1  number of valid header bytes n, range 0..W.
- ready_insert  out  1  header ready.

Behaviour:
- Reset: state IDLE, residual empty; valid_out, data_out, keep_out and last_out all 0.
- While reset is asserted, ready_in=0 and ready_insert=0.
- Output register: out_free = !valid_out || ready_out.
  - Every beat is registered, so output latency is 1 cycle after the accepting edge.
  - valid_out, data_out, keep_out and last_out stay stable while valid_out=1 and ready_out=0.
- IDLE state:
  - ready_insert=1, ready_in=0.
  - On valid_insert&&ready_insert: residual = low n bytes of data_insert (n = byte_insert_cnt, authoritative), then go to STREAM.
  - The header may be accepted while the previous packet's final beat still waits in the output register.
- STREAM state:
  - ready_in = out_free; ready_insert=0.
  - On each payload handshake, form concat = residual (n bytes) followed by the keep_in-valid bytes (k bytes); total = n+k.
  - Non-last beat: load the first W bytes of concat, keep_out all ones, last_out=0. The remaining n bytes become the residual (count unchanged).
  - Last beat, total ≤ W: load concat left-aligned, keep_out = total leading ones, last_out=1, go to IDLE.
  - Last beat, total > W: load the first W bytes (keep all ones, last_out=0), residual = remaining total-W bytes, go to FLUSH.
- FLUSH state:
  - ready_in=0, ready_insert=0.
  - When out_free: load the residual left-aligned, keep_out = residual-count leading ones, last_out=1, go to IDLE.
- Unused byte lanes of data_out are driven 0.
- n=0: pure pass-through with 1-cycle latency.
- n=W: the first output beat is the whole header.
- keep_in with zero valid bytes is illegal (payload always ≥1 byte).
- keep_insert is informational only; a simulation-only assertion flags any mismatch between keep_insert's population count and byte_insert_cnt.
- An asynchronous reset asserted mid-packet immediately returns the block to IDLE with outputs cleared; partial packet data is discarded.

Optional Feature:
- Macro HDR_CNT_FROM_KEEP_EN.
- When defined: n = population count of keep_insert, and byte_insert_cnt is ignored.
- When undefined: n = byte_insert_cnt, and keep_insert is used only by the assertion.

Test Plan:
- Header 0xAABBCCDD, cnt 2; payload 0x11223344, then 0x55667788 keep 1100 last.
  - Out 0xCCDD1122 keep 1111.
  - Out 0x33445566 keep 1111 last.
- Header 0xAABBCCDD, cnt 4; payload 0x11223344 keep 1000 last.
  - Out 0xAABBCCDD keep 1111.
  - Out 0x11000000 keep 1000 last (FLUSH).
- Header cnt 3, 0x00BBCCDD; payload 0x11223344, then 0x55667788 keep 1110 last.
  - Out 0xBBCCDD11 keep 1111.
  - Out 0x22334455 keep 1111.
  - Out 0x66770000 keep 1100 last.
- Header cnt 0; payload 0x01020304, 0x05060708 keep 1111 last.
  - Identical beats out, each 1 cycle after acceptance; last on the second beat.
- ready_out low for 3 cycles mid-packet.
  - valid_out held and data_out stable; ready_in=0.
  - No bytes lost or duplicated after release.
- rst_n pulsed high mid-packet.
  - valid_out=0 and ready_insert=0 during reset.
  - After release, ready_insert=1 and the next packet is correct.

Source files
------------

// File: rtl/axi_stream_header_insert_if.sv
// axi_stream_header_insert_if: payload, header and output stream signals of the header inserter
interface axi_stream_header_insert_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD:0]    byte_insert_cnt;
    logic                    ready_insert;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );
endinterface

// File: rtl/axi_stream_header_insert.sv
// axi_stream_header_insert: prepends the valid bytes of a header word to a payload packet (optional HDR_CNT_FROM_KEEP_EN)
module axi_stream_header_insert #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic                       clk,
    input logic                       rst_n,
    axi_stream_header_insert_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [BYTE_CNT_WD:0] W_CNT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] ONES = '1;

    function automatic logic [BYTE_CNT_WD:0] popcnt(input logic [DATA_BYTE_WD-1:0] v);
        popcnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) popcnt = popcnt + (BYTE_CNT_WD + 1)'(v[i]);
    endfunction

    logic [1:0]              state;
    logic [DATA_WD-1:0]      res_data;
    logic [BYTE_CNT_WD:0]    res_cnt;
    logic                    valid_r;
    logic [DATA_WD-1:0]      data_r;
    logic [DATA_BYTE_WD-1:0] keep_r;
    logic                    last_r;
    logic                    out_free;
    logic                    hdr_fire;
    logic                    pay_fire;
    logic                    fits;
    logic [BYTE_CNT_WD:0]    hdr_cnt;
    logic [BYTE_CNT_WD:0]    pay_cnt;
    logic [BYTE_CNT_WD:0]    flush_cnt;
    logic [BYTE_CNT_WD+1:0]  total;
    logic [DATA_WD-1:0]      data_m;
    logic [2*DATA_WD-1:0]    wide;

`ifdef HDR_CNT_FROM_KEEP_EN
    assign hdr_cnt = popcnt(bus.keep_insert);
`else
    assign hdr_cnt = bus.byte_insert_cnt;
`endif

    assign out_free         = !valid_r || bus.ready_out;
    assign bus.ready_insert = !rst_n && state == IDLE;
    assign bus.ready_in     = !rst_n && state == STREAM && out_free;
    assign hdr_fire         = bus.valid_insert && bus.ready_insert;
    assign pay_fire         = bus.valid_in && bus.ready_in;
    assign bus.valid_out    = valid_r;
    assign bus.data_out     = data_r;
    assign bus.keep_out     = keep_r;
    assign bus.last_out     = last_r;

    // zero the payload lanes keep_in marks invalid so they never reach data_out
    always_comb begin
        data_m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) data_m[8*i +: 8] = bus.keep_in[i] ? bus.data_in[8*i +: 8] : 8'h00;
    end

    // residual is right-aligned in res_data while streaming, so shifting by the
    // missing bytes lines it up ahead of the payload: upper half = next beat
    assign pay_cnt   = popcnt(bus.keep_in);
    assign total     = {1'b0, res_cnt} + {1'b0, pay_cnt};
    assign fits      = total <= {1'b0, W_CNT};
    assign flush_cnt = total[BYTE_CNT_WD:0] - W_CNT;
    assign wide      = {res_data, data_m} << {W_CNT - res_cnt, 3'b000};

    // packet FSM, residual store and registered output beat
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            res_data <= '0;
            res_cnt  <= '0;
            valid_r  <= 1'b0;
            data_r   <= '0;
            keep_r   <= '0;
            last_r   <= 1'b0;
        end else begin
            if (bus.ready_out) valid_r <= 1'b0;
            case (state)
                IDLE: if (hdr_fire) begin
                    res_data <= bus.data_insert;
                    res_cnt  <= hdr_cnt;
                    state    <= STREAM;
                end
                STREAM: if (pay_fire) begin
                    valid_r <= 1'b1;
                    data_r  <= wide[2*DATA_WD-1:DATA_WD];
                    if (!bus.last_in) begin
                        keep_r   <= ONES;
                        last_r   <= 1'b0;
                        res_data <= data_m;
                    end else if (fits) begin
                        keep_r <= ~(ONES >> total);
                        last_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        // leftover bytes kept left-aligned so FLUSH emits them as-is
                        keep_r   <= ONES;
                        last_r   <= 1'b0;
                        res_data <= wide[DATA_WD-1:0];
                        res_cnt  <= flush_cnt;
                        state    <= FLUSH;
                    end
                end
                FLUSH: if (out_free) begin
                    valid_r <= 1'b1;
                    data_r  <= res_data;
                    keep_r  <= ~(ONES >> res_cnt);
                    last_r  <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // header keep must describe the same number of bytes as byte_insert_cnt
    always_ff @(posedge clk) begin
        if (hdr_fire) assert (popcnt(bus.keep_insert) == bus.byte_insert_cnt);
    end
endmodule

// File: tb/tb_axi_stream_header_insert.sv
// tb_axi_stream_header_insert: directed vectors checked against a byte-queue packet model
`define CHK(n, a, r) check(n, 64'(a), 64'(r))
module tb_axi_stream_header_insert;
    localparam int DW = 32;
    localparam int W  = 4;

    typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t obs_log[$];
    logic [7:0] cur[$];

    always #5 clk = ~clk;

    axi_stream_header_insert_if #(.DATA_WD(DW)) bus();
    axi_stream_header_insert #(.DATA_WD(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // cut the finished packet's byte list into left-aligned output beats
    task automatic pack_packet();
        while (cur.size() > 0) begin
            int m;
            beat_t b;
            m = cur.size() < W ? cur.size() : W;
            b = '0;
            for (int j = 0; j < m; j++) begin
                b.d[8*(W-1-j) +: 8] = cur.pop_front();
                b.k[W-1-j] = 1'b1;
            end
            b.l = cur.size() == 0;
            exp_q.push_back(b);
        end
    endtask

    initial begin : mon
        beat_t now;
        beat_t held;
        logic stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            now = {bus.data_out, bus.keep_out, bus.last_out};
            if (rst_n) begin
                cur.delete();
                exp_q.delete();
                obs_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    `CHK("hold_valid", bus.valid_out, 1);
                    `CHK("hold_beat", now, held);
                end
                stall_prev = bus.valid_out && !bus.ready_out;
                held = now;
                if (bus.valid_insert && bus.ready_insert) begin
                    cur.delete();
                    for (int i = int'(bus.byte_insert_cnt) - 1; i >= 0; i--) cur.push_back(bus.data_insert[8*i +: 8]);
                end
                if (bus.valid_in && bus.ready_in) begin
                    for (int i = W - 1; i >= 0; i--) if (bus.keep_in[i]) cur.push_back(bus.data_in[8*i +: 8]);
                    if (bus.last_in) pack_packet();
                end
                if (bus.valid_out && bus.ready_out) begin
                    obs_q.push_back(now);
                    obs_log.push_back(now);
                end
                while (exp_q.size() > 0 && obs_q.size() > 0) `CHK("beat", obs_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    task automatic wait_fire(input bit pay);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (pay ? bus.ready_in : bus.ready_insert) break;
            t++;
            if (t > 50) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout actual=no_ready required=ready");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [31:0] d, input int n);
        logic [3:0] k;
        k = 4'((1 << n) - 1);
        bus.valid_insert = 1'b1;
        bus.data_insert = d;
        bus.byte_insert_cnt = 3'(n);
        bus.keep_insert = k;
        wait_fire(1'b0);
        bus.valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bus.valid_in = 1'b1;
        bus.data_in = d;
        bus.keep_in = k;
        bus.last_in = l;
        wait_fire(1'b1);
        bus.valid_in = 1'b0;
        bus.last_in = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic lit(input int base, input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t e;
        e = {d, k, l};
        if (obs_log.size() > base + idx) `CHK($sformatf("lit_beat%0d", base + idx), obs_log[base + idx], e);
        else `CHK("lit_missing", obs_log.size(), base + idx + 1);
    endtask

    initial begin
        int base;
        bus.valid_in = 1'b0;
        bus.data_in = '0;
        bus.keep_in = '0;
        bus.last_in = 1'b0;
        bus.ready_out = 1'b1;
        bus.valid_insert = 1'b0;
        bus.data_insert = '0;
        bus.keep_insert = '0;
        bus.byte_insert_cnt = '0;
        repeat (2) @(negedge clk);
        `CHK("rst_valid_out", bus.valid_out, 0);
        `CHK("rst_data_out", bus.data_out, 0);
        `CHK("rst_keep_out", bus.keep_out, 0);
        `CHK("rst_last_out", bus.last_out, 0);
        `CHK("rst_ready_insert", bus.ready_insert, 0);
        `CHK("rst_ready_in", bus.ready_in, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        `CHK("idle_ready_insert", bus.ready_insert, 1);
        `CHK("idle_ready_in", bus.ready_in, 0);
        @(posedge clk);
        #1;

        base = obs_log.size();
        send_hdr(32'hAABBCCDD, 2);
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hC, 1'b1);
        drain();
        lit(base, 0, 32'hCCDD1122, 4'hF, 1'b0);
        lit(base, 1, 32'h33445566, 4'hF, 1'b1);

        base = obs_log.size();
        send_hdr(32'hAABBCCDD, 4);
        send_beat(32'h11223344, 4'h8, 1'b1);
        drain();
        lit(base, 0, 32'hAABBCCDD, 4'hF, 1'b0);
        lit(base, 1, 32'h11000000, 4'h8, 1'b1);

        base = obs_log.size();
        send_hdr(32'h00BBCCDD, 3);
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hE, 1'b1);
        drain();
        lit(base, 0, 32'hBBCCDD11, 4'hF, 1'b0);
        lit(base, 1, 32'h22334455, 4'hF, 1'b0);
        lit(base, 2, 32'h66770000, 4'hC, 1'b1);

        base = obs_log.size();
        send_hdr(32'h0, 0);
        send_beat(32'h01020304, 4'hF, 1'b0);
        @(negedge clk);
        `CHK("pass_latency_valid", bus.valid_out, 1);
        `CHK("pass_latency_data", bus.data_out, 32'h01020304);
        @(posedge clk);
        #1;
        send_beat(32'h05060708, 4'hF, 1'b1);
        drain();
        lit(base, 0, 32'h01020304, 4'hF, 1'b0);
        lit(base, 1, 32'h05060708, 4'hF, 1'b1);

        base = obs_log.size();
        send_hdr(32'h12345678, 1);
        send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
        bus.ready_out = 1'b0;
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    `CHK("stall_ready_in", bus.ready_in, 0);
                    `CHK("stall_valid_out", bus.valid_out, 1);
                end
                @(posedge clk);
                #1 bus.ready_out = 1'b1;
            end
            send_beat(32'hB1B2B3B4, 4'hF, 1'b0);
        join
        send_beat(32'hC1C20000, 4'hC, 1'b1);
        drain();
        lit(base, 0, 32'h78A1A2A3, 4'hF, 1'b0);
        lit(base, 1, 32'hA4B1B2B3, 4'hF, 1'b0);
        lit(base, 2, 32'hB4C1C200, 4'hE, 1'b1);

        send_hdr(32'hDEADBEEF, 2);
        send_beat(32'h01020304, 4'hF, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        `CHK("midrst_valid_out", bus.valid_out, 0);
        `CHK("midrst_data_out", bus.data_out, 0);
        `CHK("midrst_ready_insert", bus.ready_insert, 0);
        `CHK("midrst_ready_in", bus.ready_in, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        `CHK("postrst_ready_insert", bus.ready_insert, 1);
        @(posedge clk);
        #1;
        base = obs_log.size();
        send_hdr(32'h000000EE, 1);
        send_beat(32'h99887766, 4'hF, 1'b1);
        drain();
        lit(base, 0, 32'hEE998877, 4'hF, 1'b0);
        lit(base, 1, 32'h66000000, 4'h8, 1'b1);

        base = obs_log.size();
        send_hdr(32'h00112233, 3);
        send_beat(32'h44000000, 4'h8, 1'b1);
        bus.ready_out = 1'b0;
        send_hdr(32'h00000055, 1);
        bus.ready_out = 1'b1;
        send_beat(32'h66778899, 4'hF, 1'b1);
        drain();
        lit(base, 0, 32'h11223344, 4'hF, 1'b1);
        lit(base, 1, 32'h55667788, 4'hF, 1'b0);
        lit(base, 2, 32'h99000000, 4'h8, 1'b1);

        `CHK("queues_empty", exp_q.size() + obs_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
